// File: rtl/boot_loader_ctrl.sv
// Boot loader: receives a framed instruction image over the UART, writes it to
// instruction memory, replies ACK/NAK, then hands UART and core over on success.
module boot_loader_ctrl #(
  parameter int unsigned DEPTH   = 2048,
  parameter logic [7:0]  MAGIC   = 8'hA5,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_irr,
  input  logic [7:0]  rx_data,
  output logic        rx_ack,
  output logic        tx_req,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        cpu_irr,
  input  logic        cpu_ack,
  input  logic        cpu_w_req,
  input  logic [7:0]  cpu_w_data,
  output logic        cpu_w_busy,
  output logic        imem_we,
  output logic [10:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        boot_done,
  output logic        boot_err
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, REPLY, RUN} state_t;

  state_t      state;
  logic        acc_r;
  logic        tx_req_r;
  logic [7:0]  tx_data_r;
  logic        reply_ack;
  logic [7:0]  csum;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [11:0] widx;
  logic [1:0]  bidx;
  logic [31:0] word;
  logic [31:0] tcnt;

  logic        run;
  logic        accept;
  logic        counting;
  logic        timed_out;
  logic [15:0] n_next;
  logic [31:0] word_next;

  assign run       = (state == RUN);
  // Blanking after an accept hides the UART's one-cycle-late irr drop.
  assign accept    = rx_irr && !acc_r && (state != RUN) && (state != REPLY);
  assign counting  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
  assign timed_out = (TIMEOUT != 0) && counting && !accept && (tcnt == 32'(TIMEOUT - 1));
  assign n_next    = {rx_data, len_lo};
  assign word_next = {rx_data, word[31:8]};

  assign rx_ack     = run ? cpu_ack    : acc_r;
  assign tx_req     = run ? cpu_w_req  : tx_req_r;
  assign tx_data    = run ? cpu_w_data : tx_data_r;
  assign cpu_irr    = run & rx_irr;
  assign cpu_w_busy = run ? tx_busy    : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc_r      <= 1'b0;
      tx_req_r   <= 1'b0;
      tx_data_r  <= '0;
      reply_ack  <= 1'b0;
      csum       <= '0;
      len_lo     <= '0;
      len        <= '0;
      widx       <= '0;
      bidx       <= '0;
      word       <= '0;
      tcnt       <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      acc_r   <= accept;
      imem_we <= 1'b0;
      if (counting && !accept) tcnt <= tcnt + 32'd1;
      else                     tcnt <= '0;

      if (timed_out) begin
        state     <= REPLY;
        reply_ack <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept && rx_data == MAGIC) begin
            state    <= LEN_LO;
            boot_err <= 1'b0;
            csum     <= '0;
            widx     <= '0;
            bidx     <= '0;
          end
          LEN_LO: if (accept) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
          LEN_HI: if (accept) begin
            len <= n_next;
            if (n_next == 16'd0 || n_next > 16'(DEPTH)) begin
              state     <= REPLY;
              reply_ack <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
          DATA: if (accept) begin
            csum <= csum + rx_data;
            word <= word_next;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_waddr <= widx[10:0];
              imem_wdata <= word_next;
              widx       <= widx + 12'd1;
              if (16'(widx) + 16'd1 == len) state <= CSUM;
            end
          end
          CSUM: if (accept) begin
            state     <= REPLY;
            reply_ack <= (rx_data == csum);
          end
          REPLY: begin
            if (tx_req_r) begin
              tx_req_r <= 1'b0;
              if (reply_ack) begin
                state     <= RUN;
                cpu_reset <= 1'b0;
                boot_done <= 1'b1;
              end else begin
                state    <= IDLE;
                boot_err <= 1'b1;
              end
            end else if (!tx_busy) begin
              tx_req_r  <= 1'b1;
              tx_data_r <= reply_ack ? 8'h06 : 8'h15;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
